// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronized, maskable edge/level interrupt controller driving a registered CPU interrupt request
module irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               sel,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               int_out
);
  logic [NUM_IRQ-1:0] s1, s2, s2_d, pending, enable, mode;
  logic [NUM_IRQ-1:0] hw_set, sw_set, clr, pending_next, enable_next, active;
  logic [2:0] word;
  logic       wr;
  logic [3:0] cause_idx;
  logic       unused;
  assign word   = addr[4:2];
  assign wr     = sel & we;
  assign unused = ^{addr[1:0], wdata[31:NUM_IRQ]};
  // Sets take priority over W1C, so a level line still high simply re-sets its bit
  always_comb begin
    hw_set       = (mode & s2 & ~s2_d) | (~mode & s2);
    sw_set       = (wr && word == 3'd4) ? wdata[NUM_IRQ-1:0] : '0;
    clr          = (wr && word == 3'd0) ? wdata[NUM_IRQ-1:0] : '0;
    pending_next = hw_set | sw_set | (pending & ~clr);
    enable_next  = (wr && word == 3'd1) ? wdata[NUM_IRQ-1:0] : enable;
    active       = pending & enable;
    cause_idx    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) cause_idx = 4'(i);
  end
  always_comb
    rdata = !(sel && !we) ? '0 :
            word == 3'd0  ? 32'(pending) :
            word == 3'd1  ? 32'(enable) :
            word == 3'd2  ? 32'(mode) :
            word == 3'd3  ? ((|active) ? {1'b1, 27'd0, cause_idx} : '0) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      s2_d    <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      int_out <= 1'b0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s2_d    <= s2;
      pending <= pending_next;
      enable  <= enable_next;
      if (wr && word == 3'd2) mode <= wdata[NUM_IRQ-1:0];
      int_out <= |(pending_next & enable_next);
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed checks of irq_ctrl against a delay-history behavioural model
module tb_irq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, we = 1'b0, int_out;
  logic [3:0]  irq_in = 4'hF;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  int passed = 0, total = 0, ncyc = 0, lit_cyc = -1;
  logic [31:0] lit_rd;
  logic        lit_int;
  string       lit_name;
  logic [3:0]  m_pend, m_en, m_mode, h1, h2, h3;
  logic        mvalid = 1'b0;

  irq_ctrl #(.NUM_IRQ(4)) dut (.clk(clk), .rst(rst), .irq_in(irq_in), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .int_out(int_out));

  always #5 clk = ~clk;

  // Model: the line value seen by the detector is irq_in two edges ago; the previous one is three edges ago
  always @(posedge clk) begin
    logic [4:0] a;
    logic set, clr;
    a = {addr[4:2], 2'b00};
    if (rst) begin
      m_pend = 0; m_en = 0; m_mode = 0; h1 = 0; h2 = 0; h3 = 0; mvalid = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        set = (m_mode[i] ? (h2[i] && !h3[i]) : h2[i]) || (sel && we && a == 5'h10 && wdata[i]);
        clr = sel && we && a == 5'h00 && wdata[i];
        if (set) m_pend[i] = 1'b1;
        else if (clr) m_pend[i] = 1'b0;
      end
      if (sel && we && a == 5'h04) m_en = wdata[3:0];
      if (sel && we && a == 5'h08) m_mode = wdata[3:0];
      h3 = h2; h2 = h1; h1 = irq_in;
    end
  end

  function automatic logic [31:0] exp_rd();
    logic [4:0] a;
    logic [3:0] act;
    a = {addr[4:2], 2'b00};
    act = m_pend & m_en;
    if (!sel || we) return 0;
    case (a)
      5'h00: return {28'd0, m_pend};
      5'h04: return {28'd0, m_en};
      5'h08: return {28'd0, m_mode};
      5'h0C: begin
        for (int i = 0; i < 4; i++) if (act[i]) return 32'h8000_0000 | i;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc %0d: got %h expected %h", name, ncyc, got, exp);
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      check("rdata", rdata, exp_rd());
      check("int_out", {31'd0, int_out}, {31'd0, |(m_pend & m_en)});
    end
    if (lit_cyc == ncyc) begin
      check({lit_name, "_rdata"}, rdata, lit_rd);
      check({lit_name, "_int"}, {31'd0, int_out}, {31'd0, lit_int});
    end
    ncyc++;
  end

  task automatic step(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; wdata = d;
    @(posedge clk);
    #2;
  endtask
  task automatic idle(); step(0, 0, 0, 0); endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 1, a, d); endtask
  task automatic chk_rd(input string name, input logic [4:0] a, input logic [31:0] e, input logic ei);
    lit_name = name; lit_rd = e; lit_int = ei; lit_cyc = ncyc;
    step(1, 0, a, 0);
  endtask

  initial begin
    idle(); idle();
    rst = 1'b0;
    chk_rd("rst_pend", 5'h00, 0, 0);
    chk_rd("rst_en", 5'h04, 0, 0);
    chk_rd("rst_mode", 5'h08, 0, 0);
    chk_rd("rst_cause", 5'h0C, 0, 0);
    chk_rd("lvl_after3", 5'h00, 32'hF, 0);
    irq_in = 4'h0;
    wr(5'h08, 32'h4);
    idle(); idle(); idle();
    wr(5'h00, 32'hF);
    wr(5'h04, 32'h4);
    chk_rd("clean", 5'h00, 0, 0);
    irq_in = 4'h4;
    idle(); idle();
    chk_rd("edge_k1", 5'h00, 0, 0);
    chk_rd("edge_k2", 5'h00, 32'h4, 1);
    chk_rd("edge_cause", 5'h0C, 32'h8000_0002, 1);
    wr(5'h00, 32'h4);
    chk_rd("edge_w1c", 5'h00, 0, 0);
    irq_in = 4'h0;
    wr(5'h04, 32'h8);
    wr(5'h10, 32'hA);
    chk_rd("prio_cause", 5'h0C, 32'h8000_0003, 1);
    wr(5'h04, 32'h0);
    chk_rd("mask_pend", 5'h00, 32'hA, 0);
    wr(5'h00, 32'hA);
    wr(5'h08, 32'h1);
    wr(5'h04, 32'h1);
    irq_in = 4'h1;
    idle(); idle();
    wr(5'h00, 32'h1);
    chk_rd("race", 5'h00, 32'h1, 1);
    wr(5'h08, 32'h0);
    irq_in = 4'h2;
    wr(5'h04, 32'h2);
    idle(); idle();
    wr(5'h00, 32'h3);
    chk_rd("lvl_hold", 5'h00, 32'h2, 1);
    irq_in = 4'h0;
    idle(); idle(); idle();
    wr(5'h00, 32'h2);
    chk_rd("lvl_clear", 5'h00, 0, 0);
    chk_rd("unmapped", 5'h14, 0, 0);
    chk_rd("swset_rd", 5'h10, 0, 0);
    wr(5'h04, 32'hFFFF_FFFF);
    chk_rd("en_upper", 5'h04, 32'hF, 0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) irq_in = 4'($urandom);
      step(1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom), $urandom);
    end
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller that sits directly upstream of the single-cycle CPU's `INT` input. It synchronizes `NUM_IRQ` asynchronous external interrupt lines, latches them as pending (edge- or level-sensitive per line), masks them with a CPU-writable enable register, and drives one registered interrupt request into the CPU. The CPU reads and clears its state through word-aligned load/store accesses decoded alongside data memory.

## Interface
- `NUM_IRQ`, default 4: number of external interrupt lines, range 1..16.
- `clk`  in  1  CPU clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  NUM_IRQ  asynchronous external interrupt lines, active-high.
- `sel`  in  1  bus select; address decoded to this block.
- `we`  in  1  write strobe; effective only when `sel`=1.
- `addr`  in  5  byte offset `[4:0]`; bits `[1:0]` ignored (word access only).
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational.
- `int_out`  out  1  registered interrupt request to the CPU `INT` input.

## Operation
- Register map (offset: name, access):
  - 0x00 PENDING, read / write-1-to-clear.
  - 0x04 ENABLE, read/write.
  - 0x08 MODE, read/write; bit=1 edge-sensitive, bit=0 level-sensitive.
  - 0x0C CAUSE, read-only: bit31 = valid, `[3:0]` = lowest-index line with pending&enable set; reads 0 when none.
  - 0x10 SWSET, write-only: bits written 1 set PENDING; reads 0.
- Only bits `[NUM_IRQ-1:0]` are implemented. Upper bits read 0 and ignore writes. Unmapped offsets read 0 and ignore writes.
- Each line passes through a 2-flop synchronizer (`s1`→`s2`) plus a `s2_d` delay flop for edge detection.
- Edge mode: a rising edge (`s2 & ~s2_d`) sets PENDING. A W1C write clears it.
- Level mode: PENDING is set each cycle while `s2`=1. A W1C write clears it only if `s2`=0 in that cycle.
- Priority per bit, per cycle: hardware set / SWSET > W1C clear > hold. A set and a clear in the same cycle leave the bit at 1.
- `int_out` next = |(PENDING_next & ENABLE_next), registered.
- `rdata` = selected register when `sel`=1 and `we`=0; otherwise 0.

## Timing
- Reset (`rst`=1 at a rising edge): `s1`, `s2`, `s2_d`, PENDING, ENABLE, MODE all clear to 0, and `int_out`=0. `rdata` follows, so CAUSE reads 0.
- External latency: `irq_in` high before edge k gives `s1`=1 after k, `s2`=1 after k+1, PENDING=1 after k+2, and `int_out`=1 after k+2.
- SWSET or ENABLE write at edge k: PENDING/ENABLE updated and `int_out` valid after edge k (one-cycle latency).
- W1C of the last active bit at edge k: `int_out`=0 after edge k, unless a same-cycle set occurs.
- Pulses shorter than one clock period may be missed. No pulse stretching is provided.
- Toggling MODE does not alter PENDING. An edge-mode line already high when switched to edge mode does not set PENDING until its next rising edge.
- `rst` asserted mid-operation discards all pending state. No interrupt fires from a line held high through reset in edge mode; level mode re-sets it 3 edges after `rst` drops.

## Test plan
- Reset: hold `irq_in`=4'b1111, `rst`=1 for 2 cycles, then read all registers → all 0 and `int_out`=0 throughout; in level mode (MODE=0), PENDING=4'hF after 3 further edges.
- Edge latency: ENABLE=4'h4, MODE=4'h4, raise `irq_in[2]` before edge k → PENDING=4'h4 and `int_out`=1 after edge k+2; CAUSE=32'h8000_0002.
- Priority/masking: SWSET 4'hA with ENABLE=4'h8 → CAUSE=32'h8000_0003 and `int_out`=1; write ENABLE=0 → `int_out`=0 next cycle, PENDING still 4'hA.
- W1C race: line 0 in edge mode, W1C 4'h1 in the same cycle its rising edge is detected → PENDING[0] stays 1 and `int_out` stays 1.
- Level hold: MODE=0, `irq_in[1]` held high, W1C 4'h2 → PENDING[1] remains 1; drop `irq_in[1]`, wait 3 cycles, W1C 4'h2 → PENDING=0 and `int_out`=0.
- Bus decode: read offset 0x14 and read SWSET → 0; write 32'hFFFF_FFFF to ENABLE → reads 32'h0000_000F.
